// File: rtl/spy_bus_arbiter_if.sv
// Bundle of the two master ports and the shared spy register bus.
// With SPY_ARB_LOCK_EN defined, each master also gets a lock input.
interface spy_bus_arbiter_if;
  logic        m0_req;
  logic        m0_write;
  logic [4:0]  m0_addr;
  logic [15:0] m0_wdata;
  logic        m0_ack;
  logic [15:0] m0_rdata;

  logic        m1_req;
  logic        m1_write;
  logic [4:0]  m1_addr;
  logic [15:0] m1_wdata;
  logic        m1_ack;
  logic [15:0] m1_rdata;

`ifdef SPY_ARB_LOCK_EN
  logic        m0_lock;
  logic        m1_lock;
`endif

  logic [4:0]  eadr;
  logic        dbread;
  logic        dbwrite;
  logic [15:0] spy_out;
  logic [15:0] spy_in;
  logic        busy;

`ifdef SPY_ARB_LOCK_EN
  modport master (
    output m0_req, m0_write, m0_addr, m0_wdata, m0_lock,
    output m1_req, m1_write, m1_addr, m1_wdata, m1_lock,
    output spy_in,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  eadr, dbread, dbwrite, spy_out, busy
  );

  modport slave (
    input  m0_req, m0_write, m0_addr, m0_wdata, m0_lock,
    input  m1_req, m1_write, m1_addr, m1_wdata, m1_lock,
    input  spy_in,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output eadr, dbread, dbwrite, spy_out, busy
  );
`else
  modport master (
    output m0_req, m0_write, m0_addr, m0_wdata,
    output m1_req, m1_write, m1_addr, m1_wdata,
    output spy_in,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  eadr, dbread, dbwrite, spy_out, busy
  );

  modport slave (
    input  m0_req, m0_write, m0_addr, m0_wdata,
    input  m1_req, m1_write, m1_addr, m1_wdata,
    input  spy_in,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output eadr, dbread, dbwrite, spy_out, busy
  );
`endif
endinterface

// File: rtl/spy_bus_arbiter.sv
// Round-robin arbiter sharing the spy register bus between two masters (setup -> strobe -> ack).
// SPY_ARB_LOCK_EN adds per-master lock inputs that keep the grant across accesses.
//
//   state     | meaning
//   ST_IDLE   | waiting for a request; eadr/spy_out hold last access
//   ST_SETUP  | address/data driven, strobes low
//   ST_STROBE | dbread or dbwrite high for ACCESS_CYCLES cycles
//   ST_DONE   | strobes low, granted ack pulses
module spy_bus_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 4
) (
  input logic              clk,
  input logic              reset_n,
  spy_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic        wr_q, wr_d;
  logic [4:0]  eadr_q, eadr_d;
  logic [15:0] spy_out_q, spy_out_d;
  logic        dbread_q, dbread_d;
  logic        dbwrite_q, dbwrite_d;
  logic        m0_ack_q, m0_ack_d;
  logic        m1_ack_q, m1_ack_d;
  logic [15:0] m0_rdata_q, m0_rdata_d;
  logic [15:0] m1_rdata_q, m1_rdata_d;
  logic        busy_q, busy_d;
`ifdef SPY_ARB_LOCK_EN
  logic        lock_q, lock_d;
`endif

  logic        req0, req1;
  logic        grant_valid;
  logic        grant_sel;

  // A held lock masks the other master out of arbitration.
  always_comb begin
    req0 = bus.m0_req;
    req1 = bus.m1_req;
`ifdef SPY_ARB_LOCK_EN
    if (lock_q) begin
      req0 = bus.m0_req & ~gnt_q;
      req1 = bus.m1_req &  gnt_q;
    end
`endif
    grant_valid = req0 | req1;
    grant_sel   = (req0 & req1) ? ~last_q : req1;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    wr_d       = wr_q;
    eadr_d     = eadr_q;
    spy_out_d  = spy_out_q;
    dbread_d   = 1'b0;
    dbwrite_d  = 1'b0;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
`ifdef SPY_ARB_LOCK_EN
    lock_d     = lock_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d = ST_SETUP;
          gnt_d   = grant_sel;
          if (grant_sel) begin
            wr_d      = bus.m1_write;
            eadr_d    = bus.m1_addr;
            spy_out_d = bus.m1_write ? bus.m1_wdata : 16'h0000;
          end else begin
            wr_d      = bus.m0_write;
            eadr_d    = bus.m0_addr;
            spy_out_d = bus.m0_write ? bus.m0_wdata : 16'h0000;
          end
        end
      end
      ST_SETUP: begin
        state_d   = ST_STROBE;
        cnt_d     = CNT_INIT;
        dbread_d  = ~wr_q;
        dbwrite_d = wr_q;
      end
      ST_STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d  = ST_DONE;
          m0_ack_d = ~gnt_q;
          m1_ack_d = gnt_q;
          if (!wr_q) begin
            if (gnt_q) m1_rdata_d = bus.spy_in;
            else       m0_rdata_d = bus.spy_in;
          end
        end else begin
          cnt_d     = cnt_q - 4'd1;
          dbread_d  = ~wr_q;
          dbwrite_d = wr_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
`ifdef SPY_ARB_LOCK_EN
        if (gnt_q ? bus.m1_lock : bus.m0_lock) begin
          lock_d = 1'b1;
        end else begin
          lock_d = 1'b0;
          last_d = gnt_q;
        end
`else
        last_d = gnt_q;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      wr_q       <= 1'b0;
      eadr_q     <= 5'd0;
      spy_out_q  <= 16'h0000;
      dbread_q   <= 1'b0;
      dbwrite_q  <= 1'b0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rdata_q <= 16'h0000;
      m1_rdata_q <= 16'h0000;
      busy_q     <= 1'b0;
`ifdef SPY_ARB_LOCK_EN
      lock_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      wr_q       <= wr_d;
      eadr_q     <= eadr_d;
      spy_out_q  <= spy_out_d;
      dbread_q   <= dbread_d;
      dbwrite_q  <= dbwrite_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      busy_q     <= busy_d;
`ifdef SPY_ARB_LOCK_EN
      lock_q     <= lock_d;
`endif
    end
  end

  assign bus.eadr     = eadr_q;
  assign bus.spy_out  = spy_out_q;
  assign bus.dbread   = dbread_q;
  assign bus.dbwrite  = dbwrite_q;
  assign bus.m0_ack   = m0_ack_q;
  assign bus.m1_ack   = m1_ack_q;
  assign bus.m0_rdata = m0_rdata_q;
  assign bus.m1_rdata = m1_rdata_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_spy_bus_arbiter.sv
// Bench for spy_bus_arbiter: directed scenarios plus random two-master traffic,
// all outputs compared every cycle against a transaction-level model.
module tb_spy_bus_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  spy_bus_arbiter_if bus ();

  spy_bus_arbiter #(.ACCESS_CYCLES(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: an access is tracked by its cycle offset from the granting edge.
  // offset 1 = setup, 2..N+1 = strobe, N+2 = ack, then back to idle.
  bit          m_busy = 1'b0;
  int          m_off = 0;
  int          m_gnt = 0;
  bit          m_wr = 1'b0;
  int          m_last = 1;
  bit          m_lock = 1'b0;
  logic [15:0] m_rdata [2] = '{16'h0, 16'h0};
  logic [4:0]  e_eadr = 5'h0;
  logic [15:0] e_spy = 16'h0;

  function automatic bit lock_of(input int g);
`ifdef SPY_ARB_LOCK_EN
    return (g == 1) ? bus.m1_lock : bus.m0_lock;
`else
    return (g < 0);
`endif
  endfunction

  task automatic model_step();
    int g;
    if (!reset_n) begin
      m_busy = 0; m_off = 0; m_gnt = 0; m_wr = 0; m_last = 1; m_lock = 0;
      m_rdata[0] = 16'h0; m_rdata[1] = 16'h0; e_eadr = 5'h0; e_spy = 16'h0;
    end else if (!m_busy) begin
      g = -1;
      if (m_lock) begin
        if (m_gnt == 0 && bus.m0_req) g = 0;
        else if (m_gnt == 1 && bus.m1_req) g = 1;
      end else if (bus.m0_req && bus.m1_req) g = 1 - m_last;
      else if (bus.m0_req) g = 0;
      else if (bus.m1_req) g = 1;
      if (g == 0) begin
        m_wr = bus.m0_write; e_eadr = bus.m0_addr;
        e_spy = bus.m0_write ? bus.m0_wdata : 16'h0;
      end else if (g == 1) begin
        m_wr = bus.m1_write; e_eadr = bus.m1_addr;
        e_spy = bus.m1_write ? bus.m1_wdata : 16'h0;
      end
      if (g >= 0) begin m_busy = 1; m_off = 1; m_gnt = g; end
    end else begin
      m_off++;
      if (m_off == N + 2 && !m_wr) m_rdata[m_gnt] = bus.spy_in;
      if (m_off == N + 3) begin
        if (lock_of(m_gnt)) m_lock = 1;
        else begin m_lock = 0; m_last = m_gnt; end
        m_busy = 0; m_off = 0;
      end
    end
  endtask

  initial begin
    bit strobe, ack;
    forever begin
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
      strobe = m_busy && m_off >= 2 && m_off <= N + 1;
      ack    = m_busy && m_off == N + 2;
      chk("busy",     16'(bus.busy),    16'(m_busy));
      chk("dbread",   16'(bus.dbread),  16'(strobe && !m_wr));
      chk("dbwrite",  16'(bus.dbwrite), 16'(strobe && m_wr));
      chk("m0_ack",   16'(bus.m0_ack),  16'(ack && m_gnt == 0));
      chk("m1_ack",   16'(bus.m1_ack),  16'(ack && m_gnt == 1));
      chk("eadr",     16'(bus.eadr),    16'(e_eadr));
      chk("spy_out",  bus.spy_out,      e_spy);
      chk("m0_rdata", bus.m0_rdata,     m_rdata[0]);
      chk("m1_rdata", bus.m1_rdata,     m_rdata[1]);
    end
  end

  int who_q[$];
  int at_q[$];

  function automatic int who_at(input int i);
    return (i < who_q.size()) ? who_q[i] : -1;
  endfunction

  function automatic int at_at(input int i);
    return (i < at_q.size()) ? at_q[i] : -1000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_masters();
    bus.m0_req = 0; bus.m1_req = 0;
`ifdef SPY_ARB_LOCK_EN
    bus.m0_lock = 0; bus.m1_lock = 0;
`endif
  endtask

  task automatic do_reset();
    reset_n = 0;
    repeat (2) tick();
    reset_n = 1;
    tick();
  endtask

  task automatic rnd_master(input bit i);
    logic req, ack, newreq;
    req = i ? bus.m1_req : bus.m0_req;
    ack = i ? bus.m1_ack : bus.m0_ack;
    newreq = 1'b0;
    if (req && ack) begin req = ($urandom_range(2) == 0); newreq = req; end
    else if (!req) begin req = ($urandom_range(3) == 0); newreq = 1'b1; end
    if (i) begin
      bus.m1_req = req;
      if (newreq) begin
        bus.m1_write = 1'($urandom_range(1)); bus.m1_addr = 5'($urandom); bus.m1_wdata = 16'($urandom);
      end
    end else begin
      bus.m0_req = req;
      if (newreq) begin
        bus.m0_write = 1'($urandom_range(1)); bus.m0_addr = 5'($urandom); bus.m0_wdata = 16'($urandom);
      end
    end
`ifdef SPY_ARB_LOCK_EN
    if (i) bus.m1_lock = ($urandom_range(3) == 0);
    else   bus.m0_lock = ($urandom_range(3) == 0);
`endif
  endtask

  initial begin
    int ack_n, rd_n, wr_n, ack_seen;
    logic [4:0] s_eadr;
    logic [15:0] s_spy;
    logic pre;

    bus.m0_req = 0; bus.m0_write = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
    bus.m1_req = 0; bus.m1_write = 0; bus.m1_addr = 0; bus.m1_wdata = 0;
    bus.spy_in = 16'h0;
`ifdef SPY_ARB_LOCK_EN
    bus.m0_lock = 0; bus.m1_lock = 0;
`endif
    repeat (3) tick();
    chk("reset_busy", 16'(bus.busy), 16'h0);
    chk("reset_eadr", 16'(bus.eadr), 16'h0);
    reset_n = 1;
    tick();

    // Read by m0 alone.
    bus.spy_in = 16'h8004;
    bus.m0_req = 1; bus.m0_write = 0; bus.m0_addr = 5'h04; bus.m0_wdata = 16'hFFFF;
    ack_n = 0; rd_n = 0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (bus.dbread) rd_n++;
      if (bus.m0_ack && ack_n == 0) begin ack_n = n; bus.m0_req = 0; end
    end
    chk("t1_ack_cycle", 16'(ack_n), 16'd6);
    chk("t1_dbread_cycles", 16'(rd_n), 16'd4);
    chk("t1_rdata", bus.m0_rdata, 16'h8004);

    // Write by m1.
    bus.spy_in = 16'hDEAD;
    bus.m1_req = 1; bus.m1_write = 1; bus.m1_addr = 5'h12; bus.m1_wdata = 16'h1234;
    ack_n = 0; rd_n = 0; wr_n = 0; s_eadr = 5'h0; s_spy = 16'h0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (n == 1) begin s_eadr = bus.eadr; s_spy = bus.spy_out; end
      if (bus.dbread) rd_n++;
      if (bus.dbwrite) wr_n++;
      if (bus.m1_ack && ack_n == 0) begin ack_n = n; bus.m1_req = 0; end
    end
    chk("t2_setup_eadr", 16'(s_eadr), 16'h0012);
    chk("t2_setup_spy_out", s_spy, 16'h1234);
    chk("t2_dbwrite_cycles", 16'(wr_n), 16'd4);
    chk("t2_dbread_cycles", 16'(rd_n), 16'd0);
    chk("t2_ack_cycle", 16'(ack_n), 16'd6);
    chk("t2_m0_rdata_kept", bus.m0_rdata, 16'h8004);
    chk("t2_m1_rdata_kept", bus.m1_rdata, 16'h0000);

    // Simultaneous reads after reset: m0 first, then m1.
    do_reset();
    bus.spy_in = 16'h3C3C;
    bus.m0_req = 1; bus.m0_write = 0; bus.m0_addr = 5'h01;
    bus.m1_req = 1; bus.m1_write = 0; bus.m1_addr = 5'h02;
    who_q.delete(); at_q.delete(); ack_seen = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (bus.m0_ack && bus.m1_ack) ack_seen++;
      if (bus.m0_ack) begin who_q.push_back(0); at_q.push_back(n); bus.m0_req = 0; bus.spy_in = 16'h5A5A; end
      if (bus.m1_ack) begin who_q.push_back(1); at_q.push_back(n); bus.m1_req = 0; end
    end
    chk("t3_ack_count", 16'(who_q.size()), 16'd2);
    chk("t3_first_master", 16'(who_at(0)), 16'd0);
    chk("t3_first_cycle", 16'(at_at(0)), 16'd6);
    chk("t3_second_master", 16'(who_at(1)), 16'd1);
    chk("t3_second_cycle", 16'(at_at(1)), 16'd13);
    chk("t3_dual_ack", 16'(ack_seen), 16'd0);
    chk("t3_m0_rdata", bus.m0_rdata, 16'h3C3C);
    chk("t3_m1_rdata", bus.m1_rdata, 16'h5A5A);

    // Continuous requests from both: alternation with 7-cycle ack spacing.
    bus.spy_in = 16'hA5A5;
    bus.m0_req = 1; bus.m1_req = 1;
    who_q.delete(); at_q.delete();
    for (int n = 1; n <= 40 && who_q.size() < 4; n++) begin
      tick();
      if (bus.m0_ack) begin who_q.push_back(0); at_q.push_back(n); end
      if (bus.m1_ack) begin who_q.push_back(1); at_q.push_back(n); end
      if (who_q.size() >= 4) begin bus.m0_req = 0; bus.m1_req = 0; end
    end
    bus.m0_req = 0; bus.m1_req = 0;
    chk("t4_first_cycle", 16'(at_at(0)), 16'd6);
    for (int i = 0; i < 4; i++) chk("t4_grant_order", 16'(who_at(i)), 16'(i % 2));
    for (int i = 0; i < 3; i++) chk("t4_ack_spacing", 16'(at_at(i + 1) - at_at(i)), 16'd7);
    repeat (3) tick();

    // Async reset during the strobe phase.
    bus.spy_in = 16'h1111;
    bus.m0_req = 1; bus.m0_write = 0; bus.m0_addr = 5'h07;
    pre = 0;
    for (int n = 1; n <= 3; n++) begin
      tick();
      if (n == 3) pre = bus.dbread;
    end
    chk("t5_strobe_before", 16'(pre), 16'h1);
    #1 reset_n = 0;
    #1;
    chk("t5_dbread_async", 16'(bus.dbread), 16'h0);
    chk("t5_dbwrite_async", 16'(bus.dbwrite), 16'h0);
    chk("t5_busy_async", 16'(bus.busy), 16'h0);
    chk("t5_m0_rdata_clr", bus.m0_rdata, 16'h0);
    chk("t5_m1_rdata_clr", bus.m1_rdata, 16'h0);
    bus.m0_req = 0;
    ack_seen = 0;
    for (int n = 0; n < 3; n++) begin
      tick();
      if (bus.m0_ack || bus.m1_ack) ack_seen++;
    end
    chk("t5_no_ack", 16'(ack_seen), 16'd0);
    reset_n = 1;
    tick();

`ifdef SPY_ARB_LOCK_EN
    // Locked m0 keeps the bus for three accesses while m1 waits.
    do_reset();
    bus.spy_in = 16'h0F0F;
    bus.m0_req = 1; bus.m0_write = 0; bus.m0_addr = 5'h03; bus.m0_lock = 1;
    bus.m1_req = 1; bus.m1_write = 1; bus.m1_addr = 5'h09; bus.m1_wdata = 16'hBEEF;
    who_q.delete(); at_q.delete(); ack_n = 0;
    for (int n = 1; n <= 50; n++) begin
      tick();
      if (bus.m0_ack) begin
        who_q.push_back(0); ack_n++;
        if (ack_n == 3) begin bus.m0_req = 0; bus.m0_lock = 0; end
      end
      if (bus.m1_ack) begin who_q.push_back(1); bus.m1_req = 0; end
    end
    idle_masters();
    chk("t6_ack_count", 16'(who_q.size()), 16'd4);
    for (int i = 0; i < 4; i++) chk("t6_grant_order", 16'(who_at(i)), 16'(i == 3));
`endif

    // Random traffic from both masters.
    for (int c = 0; c < 4000; c++) begin
      tick();
      bus.spy_in = 16'($urandom);
      rnd_master(1'b0);
      rnd_master(1'b1);
      if (c == 2000) begin
        #1 reset_n = 0;
        tick();
        reset_n = 1;
      end
    end
    idle_masters();
    repeat (30) tick();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
